// File: rtl/llpg_pkg.sv
// Shared definitions for the linked-list page manager.
//   - default geometry (pointer width, page count, client counts, low mark)
//   - page_t / cnt_t pointer and count types
//   - state_t FSM encoding (INIT fills the free list, RUN serves clients)
//   - rr_next(): round-robin pick used by llpg_rrarb
package llpg_pkg;

    localparam int LPSZ    = 8;
    localparam int PAGES   = 256;
    localparam int SOURCES = 4;
    localparam int SINKS   = 4;
    localparam int LOWMARK = 16;

    // Widest request vector rr_next() can arbitrate.
    localparam int RR_MAX  = 32;

    typedef logic [LPSZ-1:0] page_t;
    typedef logic [LPSZ:0]   cnt_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One-hot pick of the next requester after the one-hot 'last'.
    // Requesters strictly above 'last' are preferred; if there are none,
    // fall back to the lowest-index requester (wrap-around).
    function automatic logic [RR_MAX-1:0] rr_next(input logic [RR_MAX-1:0] req,
                                                  input logic [RR_MAX-1:0] last);
        logic [RR_MAX-1:0] upper;
        upper = req & ~((last << 1) - RR_MAX'(1));
        if (upper != '0) begin
            return upper & (~upper + RR_MAX'(1));
        end
        return req & (~req + RR_MAX'(1));
    endfunction

endpackage

// File: rtl/llpage_mgr_if.sv
// Client bus of the page manager: page allocation and chain return.
//   pgreq      per-source allocation request (level)
//   lprq_*     allocated-page channel, one-hot srdy, shared page bus
//   lprt_*     chain-return channel, per-sink head/tail/count, one-hot drdy
// Handshake: a transfer happens on a rising clk edge where srdy and drdy are
// both high for the same client bit. Once raised, srdy and its payload stay
// stable until that transfer. lprq_drdy may depend on nothing the manager
// drives in the same cycle; lprt_drdy is combinational on lprt_srdy.
// modport master = client side, modport slave = page manager.
interface llpage_mgr_if #(
    parameter int lpsz    = 8,
    parameter int sources = 4,
    parameter int sinks   = 4
);
    logic [sources-1:0]        pgreq;
    logic [sources-1:0]        lprq_srdy;
    logic [sources-1:0]        lprq_drdy;
    logic [lpsz-1:0]           lprq_page;
    logic [sinks-1:0]          lprt_srdy;
    logic [sinks-1:0]          lprt_drdy;
    logic [sinks*lpsz-1:0]     lprt_head;
    logic [sinks*lpsz-1:0]     lprt_tail;
    logic [sinks*(lpsz+1)-1:0] lprt_cnt;

    modport master (
        output pgreq, lprq_drdy, lprt_srdy, lprt_head, lprt_tail, lprt_cnt,
        input  lprq_srdy, lprq_page, lprt_drdy
    );

    modport slave (
        input  pgreq, lprq_drdy, lprt_srdy, lprt_head, lprt_tail, lprt_cnt,
        output lprq_srdy, lprq_page, lprt_drdy
    );
endinterface

// File: rtl/llpg_rrarb.sv
// Round-robin arbiter with a registered last-grant pointer.
//   clk, reset  clock, asynchronous active-low reset (last grant = client 0)
//   req         request vector
//   adv         grant consumed this cycle: move the pointer to 'grant'
//   grant       one-hot winner, combinational on req and the pointer
module llpg_rrarb
    import llpg_pkg::*;
#(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] req,
    input  logic             adv,
    output logic [width-1:0] grant
);

    logic [width-1:0] last;

    assign grant = width'(rr_next(RR_MAX'(req), RR_MAX'(last)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= width'(1);
        end else if (adv && (req != '0)) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/llpage_mgr.sv
// Linked-list page manager: owns the free-page list and the next-pointer RAM.
//   clk, reset     clock, asynchronous active-low reset (re-enters INIT)
//   bus            allocation / chain-return channels (llpage_mgr_if.slave)
//   lnk_wr_*       client write of a page's next pointer (RUN only)
//   lnk_rd_addr    next-pointer read address
//   lnk_rd_data    registered read data, one cycle latency, pre-write value
//   free_cnt       pages on the free list
//   free_low       registered free_cnt < lowmark
//   init_done      free list initialised, RUN reached
//   dbg_state      current FSM state
module llpage_mgr
    import llpg_pkg::*;
#(
    parameter int lpsz    = LPSZ,
    parameter int pages   = PAGES,
    parameter int sources = SOURCES,
    parameter int sinks   = SINKS,
    parameter int lowmark = LOWMARK
) (
    input  logic            clk,
    input  logic            reset,
    llpage_mgr_if.slave     bus,
    input  logic            lnk_wr_en,
    input  logic [lpsz-1:0] lnk_wr_addr,
    input  logic [lpsz-1:0] lnk_wr_data,
    input  logic [lpsz-1:0] lnk_rd_addr,
    output logic [lpsz-1:0] lnk_rd_data,
    output logic [lpsz:0]   free_cnt,
    output logic            free_low,
    output logic            init_done,
    output state_t          dbg_state
);

    localparam logic [lpsz-1:0] LAST_PAGE = lpsz'(pages - 1);
    localparam logic [lpsz:0]   FULL_CNT  = (lpsz+1)'(pages);
    localparam logic [lpsz+1:0] FULL_SUM  = (lpsz+2)'(pages);
    localparam logic [lpsz:0]   LOW_CNT   = (lpsz+1)'(lowmark);
    localparam logic [lpsz:0]   MIN_ALLOC = (lpsz+1)'(2);

    state_t          state, state_nxt;
    logic            run;
    logic [lpsz-1:0] init_idx;
    logic [lpsz-1:0] init_data;

    logic [lpsz-1:0] pglist [pages];
    logic [lpsz-1:0] free_head, free_tail;

    logic [sources-1:0] rq_grant;
    logic [sinks-1:0]   rt_req, rt_grant;
    logic               slot_free, alloc, reclaim;
    logic [lpsz-1:0]    rt_head, rt_tail;
    logic [lpsz:0]      rt_cnt;
    logic [lpsz+1:0]    cnt_sum;
    logic [lpsz:0]      cnt_nxt;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            init_idx <= '0;
        end else begin
            state    <= state_nxt;
            init_idx <= (state == INIT) ? init_idx + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        case (state)
            INIT: if (init_idx == LAST_PAGE) state_nxt = RUN;
            RUN:  run = 1'b1;
        endcase
    end

    assign init_done = (state == RUN);
    assign dbg_state = state;
    // Last entry wraps to page 0 so the initial list is a ring mod pages.
    assign init_data = (init_idx == LAST_PAGE) ? '0 : init_idx + 1'b1;

    // ---------------- arbitration ----------------
    // The output slot can take a new page when empty or when it drains now.
    assign slot_free = (bus.lprq_srdy == '0) || ((bus.lprq_srdy & bus.lprq_drdy) != '0);
    // One page always stays behind as the tail anchor of the free list.
    assign alloc     = run && (free_cnt >= MIN_ALLOC) && slot_free && (bus.pgreq != '0);

    llpg_rrarb #(.width(sources)) u_rq_arb (
        .clk   (clk),
        .reset (reset),
        .req   (bus.pgreq),
        .adv   (alloc),
        .grant (rq_grant)
    );

    assign rt_req        = run ? bus.lprt_srdy : '0;
    assign bus.lprt_drdy = rt_grant;
    assign reclaim       = (rt_grant != '0);

    llpg_rrarb #(.width(sinks)) u_rt_arb (
        .clk   (clk),
        .reset (reset),
        .req   (rt_req),
        .adv   (reclaim),
        .grant (rt_grant)
    );

    always_comb begin
        rt_head = '0;
        rt_tail = '0;
        rt_cnt  = '0;
        for (int i = 0; i < sinks; i++) begin
            if (rt_grant[i]) begin
                rt_head = bus.lprt_head[i*lpsz +: lpsz];
                rt_tail = bus.lprt_tail[i*lpsz +: lpsz];
                rt_cnt  = bus.lprt_cnt[i*(lpsz+1) +: (lpsz+1)];
            end
        end
    end

    // rt_cnt is zero without a reclaim, so one adder covers all four cases.
    assign cnt_sum = (lpsz+2)'(free_cnt) + (lpsz+2)'(rt_cnt) - (lpsz+2)'(alloc);
    assign cnt_nxt = (cnt_sum > FULL_SUM) ? FULL_CNT : cnt_sum[lpsz:0];

    // ---------------- free list state ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.lprq_srdy <= '0;
            bus.lprq_page <= '0;
            free_head     <= '0;
            free_tail     <= LAST_PAGE;
            free_cnt      <= FULL_CNT;
            free_low      <= (pages < lowmark);
            lnk_rd_data   <= '0;
        end else begin
            lnk_rd_data <= pglist[lnk_rd_addr];
            free_cnt    <= cnt_nxt;
            free_low    <= (cnt_nxt < LOW_CNT);
            if (alloc) begin
                bus.lprq_srdy <= rq_grant;
                bus.lprq_page <= free_head;
                free_head     <= pglist[free_head];
            end else if (slot_free) begin
                bus.lprq_srdy <= '0;
            end
            if (reclaim) begin
                free_tail <= rt_tail;
            end
        end
    end

    // ---------------- next-pointer RAM ----------------
    // The reclaim write comes last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            pglist[init_idx] <= init_data;
        end else begin
            if (lnk_wr_en) pglist[lnk_wr_addr] <= lnk_wr_data;
            if (reclaim)   pglist[free_tail]   <= rt_head;
        end
    end

endmodule

// File: tb/tb_llpage_mgr.sv
// Directed bench for llpage_mgr: reset/INIT timing, round-robin allocation,
// stall hold, async reset mid-stream, chain reclaim and link-port behaviour.
module tb_llpage_mgr;
    import llpg_pkg::*;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   reset;
    always #5 clk = ~clk;

    logic   lnk_wr_en;
    page_t  lnk_wr_addr, lnk_wr_data, lnk_rd_addr, lnk_rd_data;
    cnt_t   free_cnt;
    logic   free_low, init_done;
    state_t dbg_state;

    llpage_mgr_if #(.lpsz(LPSZ), .sources(SOURCES), .sinks(SINKS)) bus ();

    llpage_mgr #(
        .lpsz(LPSZ), .pages(PAGES), .sources(SOURCES), .sinks(SINKS), .lowmark(LOWMARK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .lnk_wr_en   (lnk_wr_en),
        .lnk_wr_addr (lnk_wr_addr),
        .lnk_wr_data (lnk_wr_data),
        .lnk_rd_addr (lnk_rd_addr),
        .lnk_rd_data (lnk_rd_data),
        .free_cnt    (free_cnt),
        .free_low    (free_low),
        .init_done   (init_done),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [LPSZ-1:0] exp_q[$];
    int last_src;
    cnt_t ret_cnt;

    typedef struct {
        logic [3:0] srdy;
        logic [7:0] page;
        logic [3:0] exp_drdy;
        logic [8:0] exp_cnt;
    } rt_vec_t;
    rt_vec_t rt_tab[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A returned chain must never push the free count beyond the page total.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.lprt_drdy != '0) begin
            ret_cnt = '0;
            for (int s = 0; s < SINKS; s++)
                if (bus.lprt_drdy[s]) ret_cnt = bus.lprt_cnt[s*(LPSZ+1) +: (LPSZ+1)];
            assert (int'(free_cnt) + int'(ret_cnt) <= PAGES)
                else $error("chain return overflows the free list");
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sink(input int s, input page_t head, input page_t tail, input cnt_t cnt);
        bus.lprt_head[s*LPSZ +: LPSZ]         = head;
        bus.lprt_tail[s*LPSZ +: LPSZ]         = tail;
        bus.lprt_cnt[s*(LPSZ+1) +: (LPSZ+1)]  = cnt;
    endtask

    function automatic int rr_pick(input logic [3:0] req);
        for (int d = 1; d <= 4; d++)
            if (req[(last_src + d) % 4]) return (last_src + d) % 4;
        return 0;
    endfunction

    // Release reset (caller sits just after a rising edge) and time INIT.
    task automatic wait_init();
        int seen;
        seen  = 0;
        reset = 1'b1;
        for (int cyc = 1; cyc <= 400 && seen == 0; cyc++) begin
            tick();
            if (init_done) seen = cyc;
            if (cyc == 10) begin
                bus.lprt_srdy = 4'b0001;
                set_sink(0, 8'd40, 8'd40, 9'd1);
                bus.pgreq = 4'b1111;
            end
            if (cyc == 11) begin
                check("init_no_reclaim", 32'(bus.lprt_drdy), 32'h0);
                check("init_no_grant", 32'(bus.lprq_srdy), 32'h0);
                bus.lprt_srdy = '0;
                bus.pgreq     = '0;
            end
            if (cyc == 200) begin
                lnk_wr_en   = 1'b1;
                lnk_wr_addr = 8'd5;
                lnk_wr_data = 8'h63;
            end
            if (cyc == 201) lnk_wr_en = 1'b0;
        end
        check("init_cycles", 32'(seen), 32'd256);
        check("init_free_cnt", 32'(free_cnt), 32'd256);
        check("init_free_low", 32'(free_low), 32'd0);
        lnk_rd_addr = 8'd5;
        tick();
        check("init_link_5_wr_ignored", 32'(lnk_rd_data), 32'd6);
        lnk_rd_addr = 8'd255;
        tick();
        check("init_link_wrap", 32'(lnk_rd_data), 32'd0);
        last_src = 0;
    endtask

    // Request with drdy held high; each grant is checked against the
    // round-robin model and the expected page queue, then the slot drains.
    task automatic alloc_run(input logic [3:0] req, input int n);
        int src;
        logic [LPSZ-1:0] exp_page;
        bus.lprq_drdy = 4'b1111;
        bus.pgreq     = req;
        for (int k = 0; k < n; k++) begin
            tick();
            src      = rr_pick(req);
            exp_page = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("alloc_srdy", 32'(bus.lprq_srdy), 32'(1) << src);
            check("alloc_page", 32'(bus.lprq_page), 32'(exp_page));
            last_src = src;
        end
        bus.pgreq = '0;
        tick();
        check("alloc_drained", 32'(bus.lprq_srdy), 32'h0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset         = 1'b0;
        bus.pgreq     = '0;
        bus.lprq_drdy = '0;
        bus.lprt_srdy = '0;
        bus.lprt_head = '0;
        bus.lprt_tail = '0;
        bus.lprt_cnt  = '0;
        lnk_wr_en     = 1'b0;
        lnk_wr_addr   = '0;
        lnk_wr_data   = '0;
        lnk_rd_addr   = '0;
        last_src      = 0;

        rt_tab[0] = '{4'b1010, 8'd10, 4'b0010, 9'd2};
        rt_tab[1] = '{4'b1010, 8'd11, 4'b1000, 9'd3};
        rt_tab[2] = '{4'b1010, 8'd12, 4'b0010, 9'd4};
        rt_tab[3] = '{4'b1010, 8'd13, 4'b1000, 9'd5};
        rt_tab[4] = '{4'b1010, 8'd14, 4'b0010, 9'd6};
        rt_tab[5] = '{4'b1010, 8'd15, 4'b1000, 9'd7};
        rt_tab[6] = '{4'b0000, 8'd99, 4'b0000, 9'd7};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_lprq_srdy", 32'(bus.lprq_srdy), 32'h0);
        check("rst_lprt_drdy", 32'(bus.lprt_drdy), 32'h0);
        check("rst_lprq_page", 32'(bus.lprq_page), 32'h0);
        check("rst_lnk_rd_data", 32'(lnk_rd_data), 32'h0);
        check("rst_free_cnt", 32'(free_cnt), 32'd256);
        check("rst_free_low", 32'(free_low), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(INIT));
        tick();
        wait_init();
        check("run_state", 32'(dbg_state), 32'(RUN));

        // Source 2 granted and stalled; grant held while others request / pgreq drops
        bus.pgreq     = 4'b0100;
        bus.lprq_drdy = 4'b0000;
        tick();
        check("stall_first_srdy", 32'(bus.lprq_srdy), 32'b0100);
        check("stall_first_page", 32'(bus.lprq_page), 32'd0);
        check("stall_first_cnt", 32'(free_cnt), 32'd255);
        for (int i = 0; i < 5; i++) begin
            bus.pgreq = (i < 3) ? 4'b1011 : 4'b0000;
            tick();
            check("stall_srdy", 32'(bus.lprq_srdy), 32'b0100);
            check("stall_page", 32'(bus.lprq_page), 32'd0);
            check("stall_cnt", 32'(free_cnt), 32'd255);
        end

        // Asynchronous reset in the middle of a cycle with srdy high
        #3 reset = 1'b0;
        #1;
        check("areset_srdy", 32'(bus.lprq_srdy), 32'h0);
        check("areset_page", 32'(bus.lprq_page), 32'h0);
        check("areset_free_cnt", 32'(free_cnt), 32'd256);
        check("areset_init_done", 32'(init_done), 32'd0);
        check("areset_state", 32'(dbg_state), 32'(INIT));
        tick();
        wait_init();

        // Full drain: pages 0..254 to sources 1,2,3,0,..., anchor page kept
        for (int p = 0; p < 255; p++) exp_q.push_back(LPSZ'(p));
        alloc_run(4'b1111, 255);
        check("drain_free_cnt", 32'(free_cnt), 32'd1);
        check("drain_free_low", 32'(free_low), 32'd1);
        bus.pgreq = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_no_grant", 32'(bus.lprq_srdy), 32'h0);
        end
        bus.pgreq = '0;
        check("drain_cnt_hold", 32'(free_cnt), 32'd1);

        // Sinks 1 and 3 returning single pages alternately
        for (int i = 0; i < 7; i++) begin
            bus.lprt_srdy = rt_tab[i].srdy;
            set_sink(1, rt_tab[i].page, rt_tab[i].page, 9'd1);
            set_sink(3, rt_tab[i].page, rt_tab[i].page, 9'd1);
            @(negedge clk);
            check("rt_drdy", 32'(bus.lprt_drdy), 32'(rt_tab[i].exp_drdy));
            tick();
            check("rt_free_cnt", 32'(free_cnt), 32'(rt_tab[i].exp_cnt));
        end
        bus.lprt_srdy = '0;
        exp_q.push_back(8'd255);
        for (int p = 10; p < 15; p++) exp_q.push_back(LPSZ'(p));
        alloc_run(4'b0001, 6);
        check("rt_realloc_cnt", 32'(free_cnt), 32'd1);

        // Fresh list for the chain-return scenario
        reset = 1'b0;
        tick();
        wait_init();
        for (int p = 0; p < 10; p++) exp_q.push_back(LPSZ'(p));
        alloc_run(4'b0001, 10);
        check("chain_cnt_10", 32'(free_cnt), 32'd246);

        // Link 3->7; registered read returns the pre-write value first
        lnk_wr_en   = 1'b1;
        lnk_wr_addr = 8'd3;
        lnk_wr_data = 8'd7;
        lnk_rd_addr = 8'd3;
        tick();
        lnk_wr_en = 1'b0;
        check("link_rd_prewrite", 32'(lnk_rd_data), 32'd4);
        tick();
        check("link_rd_postwrite", 32'(lnk_rd_data), 32'd7);

        // Chain 3..7 returned by sink 1 in the same cycle as an allocation
        bus.pgreq     = 4'b0001;
        bus.lprt_srdy = 4'b0010;
        set_sink(1, 8'd3, 8'd7, 9'd2);
        @(negedge clk);
        check("both_drdy", 32'(bus.lprt_drdy), 32'b0010);
        tick();
        check("both_srdy", 32'(bus.lprq_srdy), 32'b0001);
        check("both_page", 32'(bus.lprq_page), 32'd10);
        check("both_free_cnt", 32'(free_cnt), 32'd247);
        bus.pgreq     = '0;
        bus.lprt_srdy = '0;
        tick();
        check("both_drained", 32'(bus.lprq_srdy), 32'h0);
        last_src = 0;

        for (int p = 11; p < 256; p++) exp_q.push_back(LPSZ'(p));
        exp_q.push_back(8'd3);
        alloc_run(4'b1111, 246);
        check("chain_anchor_cnt", 32'(free_cnt), 32'd1);

        // Return page 0 from sink 0 while a link write hits the same entry
        bus.lprt_srdy = 4'b0001;
        set_sink(0, 8'd0, 8'd0, 9'd1);
        lnk_wr_en   = 1'b1;
        lnk_wr_addr = 8'd7;
        lnk_wr_data = 8'h55;
        @(negedge clk);
        check("ret0_drdy", 32'(bus.lprt_drdy), 32'b0001);
        tick();
        bus.lprt_srdy = '0;
        lnk_wr_en     = 1'b0;
        check("ret0_free_cnt", 32'(free_cnt), 32'd2);
        lnk_rd_addr = 8'd7;
        tick();
        check("collide_reclaim_wins", 32'(lnk_rd_data), 32'd0);
        exp_q.push_back(8'd7);
        alloc_run(4'b0001, 1);
        check("final_free_cnt", 32'(free_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
